// File: rtl/key_debounce.sv
// Pushbutton and slide-switch conditioner: synchronize, debounce, edge pulses.
// Optional auto-repeat on held keys is built only when KEY_REPEAT_EN is defined.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [3:0]  KEY_IN,
  input  logic [17:0] SW_IN,
  output logic [3:0]  KEY_LEVEL,
  output logic [3:0]  KEY_PRESS,
  output logic [3:0]  KEY_RELEASE,
  output logic [17:0] SW_OUT,
  output logic        SW_CHANGED
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] KEY_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
  // The switch counter restarts on the first sample of a new value, so it
  // terminates one count earlier to give the same overall latency as a key.
  localparam logic [CNT_W-1:0] SW_TC = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [3:0]       key_sync1, key_sync2;
  logic [17:0]      sw_sync1, sw_sync2, sw_prev;
  logic [CNT_W-1:0] key_cnt [4];
  logic [CNT_W-1:0] sw_cnt;
  logic [3:0]       key_mismatch;
  logic [3:0]       key_accept;
  logic [3:0]       key_repeat;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_sync1 <= '1;
      key_sync2 <= '1;
      sw_sync1  <= '0;
      sw_sync2  <= '0;
    end else begin
      key_sync1 <= KEY_IN;
      key_sync2 <= key_sync1;
      sw_sync1  <= SW_IN;
      sw_sync2  <= sw_sync1;
    end
  end

  always_comb begin
    key_mismatch = ~key_sync2 ^ KEY_LEVEL;
    key_accept   = '0;
    for (int i = 0; i < 4; i++) begin
      key_accept[i] = key_mismatch[i] && (key_cnt[i] == KEY_TC);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 4; i++) begin
        key_cnt[i] <= '0;
      end
      KEY_LEVEL   <= '0;
      KEY_PRESS   <= '0;
      KEY_RELEASE <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!key_mismatch[i] || key_accept[i]) begin
          key_cnt[i] <= '0;
        end else begin
          key_cnt[i] <= key_cnt[i] + 1'b1;
        end
      end
      KEY_LEVEL   <= KEY_LEVEL ^ key_accept;
      KEY_PRESS   <= (key_accept & ~KEY_LEVEL) | key_repeat;
      KEY_RELEASE <= key_accept & KEY_LEVEL;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_LD  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LD = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt [4];

  // A release on the same edge as terminal count wins: no repeat pulse.
  always_comb begin
    key_repeat = '0;
    for (int i = 0; i < 4; i++) begin
      key_repeat[i] = KEY_LEVEL[i] && !key_accept[i] && (rep_cnt[i] == '0);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 4; i++) begin
        rep_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (key_accept[i]) begin
          rep_cnt[i] <= KEY_LEVEL[i] ? '0 : REP_DELAY_LD;
        end else if (KEY_LEVEL[i]) begin
          rep_cnt[i] <= (rep_cnt[i] == '0) ? REP_PERIOD_LD : rep_cnt[i] - 1'b1;
        end
      end
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign key_repeat = '0;
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_prev    <= '0;
      sw_cnt     <= '0;
      SW_OUT     <= '0;
      SW_CHANGED <= 1'b0;
    end else begin
      sw_prev    <= sw_sync2;
      SW_CHANGED <= 1'b0;
      if (sw_sync2 == SW_OUT || sw_sync2 != sw_prev) begin
        sw_cnt <= '0;
      end else if (sw_cnt == SW_TC) begin
        sw_cnt     <= '0;
        SW_OUT     <= sw_sync2;
        SW_CHANGED <= 1'b1;
      end else begin
        sw_cnt <= sw_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_key_debounce;

  logic        CLOCK_50;
  logic        RESET_N;
  logic [3:0]  KEY_IN;
  logic [17:0] SW_IN;
  logic [3:0]  KEY_LEVEL, KEY_PRESS, KEY_RELEASE;
  logic [17:0] SW_OUT;
  logic        SW_CHANGED;

  key_debounce #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N(RESET_N),
    .KEY_IN(KEY_IN),
    .SW_IN(SW_IN),
    .KEY_LEVEL(KEY_LEVEL),
    .KEY_PRESS(KEY_PRESS),
    .KEY_RELEASE(KEY_RELEASE),
    .SW_OUT(SW_OUT),
    .SW_CHANGED(SW_CHANGED)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int          cyc;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic [3:0]  level;
    logic [17:0] sw;
    logic        swc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [3:0]  cur_level = '0;
  logic [17:0] cur_sw = '0;
  logic [30:0] obs;

  assign obs = {KEY_PRESS, KEY_RELEASE, KEY_LEVEL, SW_OUT, SW_CHANGED};

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    cyc++;
  endtask

  task automatic push_ev(input int c, input logic [3:0] p, input logic [3:0] r,
                         input logic [3:0] l, input logic [17:0] s, input logic w);
    exp_t x;
    x.cyc = c; x.press = p; x.rel = r; x.level = l; x.sw = s; x.swc = w;
    sb.push_back(x);
  endtask

  // Expected output vector for the edge just taken; quiet cycles hold levels, no pulses.
  function automatic logic [30:0] exp_now();
    exp_t x;
    logic [30:0] e;
    e = {4'b0, 4'b0, cur_level, cur_sw, 1'b0};
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      x = sb.pop_front();
      cur_level = x.level;
      cur_sw    = x.sw;
      e = {x.press, x.rel, x.level, x.sw, x.swc};
    end
    return e;
  endfunction

  task automatic test_reset();
    logic [30:0] e;
    RESET_N = 1'b1; KEY_IN = 4'hF; SW_IN = '0;
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if (obs !== 31'd0) begin
      failures++; $display("FAIL reset_async got=%h exp=%h", obs, 31'd0);
    end
    for (int k = 0; k < 3; k++) begin
      tick(); e = exp_now(); checks++;
      if (obs !== e) begin failures++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, obs, e); end
    end
    RESET_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); e = exp_now(); checks++;
      if (obs !== e) begin failures++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs, e); end
    end
  endtask

  task automatic test_key_press();
    logic [30:0] e;
    int c0 = cyc;
    KEY_IN[0] = 1'b0;
    push_ev(c0 + 6, 4'b0001, 4'b0000, 4'b0001, 18'h0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick(); e = exp_now(); checks++;
      if (obs !== e) begin failures++; $display("FAIL key_press cyc=%0d got=%h exp=%h", cyc, obs, e); end
    end
  endtask

  task automatic test_glitch();
    logic [30:0] e;
    KEY_IN[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(); e = exp_now(); checks++;
      if (obs !== e) begin failures++; $display("FAIL glitch_low cyc=%0d got=%h exp=%h", cyc, obs, e); end
    end
    KEY_IN[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(); e = exp_now(); checks++;
      if (obs !== e) begin failures++; $display("FAIL glitch_after cyc=%0d got=%h exp=%h", cyc, obs, e); end
    end
  endtask

  task automatic test_min_pulse();
    logic [30:0] e;
    int c0 = cyc;
    KEY_IN[1] = 1'b0;
    push_ev(c0 + 6,  4'b0010, 4'b0000, 4'b0011, 18'h0, 1'b0);
    push_ev(c0 + 10, 4'b0000, 4'b0010, 4'b0001, 18'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick(); e = exp_now(); checks++;
      if (obs !== e) begin failures++; $display("FAIL min_pulse_low cyc=%0d got=%h exp=%h", cyc, obs, e); end
    end
    KEY_IN[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(); e = exp_now(); checks++;
      if (obs !== e) begin failures++; $display("FAIL min_pulse cyc=%0d got=%h exp=%h", cyc, obs, e); end
    end
  endtask

  task automatic test_switch();
    logic [30:0] e;
    int c0 = cyc;
    int c1;
    SW_IN = 18'h2A5A5;
    push_ev(c0 + 6, 4'b0, 4'b0, 4'b0001, 18'h2A5A5, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick(); e = exp_now(); checks++;
      if (obs !== e) begin failures++; $display("FAIL sw_load cyc=%0d got=%h exp=%h", cyc, obs, e); end
    end
    c1 = cyc;
    SW_IN = 18'h15A5A;
    for (int k = 0; k < 2; k++) begin
      tick(); e = exp_now(); checks++;
      if (obs !== e) begin failures++; $display("FAIL sw_first cyc=%0d got=%h exp=%h", cyc, obs, e); end
    end
    SW_IN = 18'h3FFFF;
    push_ev(c1 + 8, 4'b0, 4'b0, 4'b0001, 18'h3FFFF, 1'b1);
    for (int k = 0; k < 12; k++) begin
      tick(); e = exp_now(); checks++;
      if (obs !== e) begin failures++; $display("FAIL sw_restart cyc=%0d got=%h exp=%h", cyc, obs, e); end
    end
  endtask

  task automatic test_repeat();
    logic [30:0] e;
    int c0 = cyc;
    KEY_IN[2] = 1'b0;
    push_ev(c0 + 6, 4'b0100, 4'b0, 4'b0101, 18'h3FFFF, 1'b0);
`ifdef KEY_REPEAT_EN
    push_ev(c0 + 16, 4'b0100, 4'b0, 4'b0101, 18'h3FFFF, 1'b0);
    push_ev(c0 + 19, 4'b0100, 4'b0, 4'b0101, 18'h3FFFF, 1'b0);
    push_ev(c0 + 22, 4'b0100, 4'b0, 4'b0101, 18'h3FFFF, 1'b0);
`endif
    for (int k = 0; k < 18; k++) begin
      tick(); e = exp_now(); checks++;
      if (obs !== e) begin failures++; $display("FAIL repeat_hold cyc=%0d got=%h exp=%h", cyc, obs, e); end
    end
    KEY_IN[2] = 1'b1;
    push_ev(c0 + 24, 4'b0, 4'b0100, 4'b0001, 18'h3FFFF, 1'b0);
    for (int k = 0; k < 12; k++) begin
      tick(); e = exp_now(); checks++;
      if (obs !== e) begin failures++; $display("FAIL repeat_release cyc=%0d got=%h exp=%h", cyc, obs, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [30:0] e;
    int cr;
    KEY_IN[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(); e = exp_now(); checks++;
      if (obs !== e) begin failures++; $display("FAIL mid_pending cyc=%0d got=%h exp=%h", cyc, obs, e); end
    end
    #1 RESET_N = 1'b0;
    #1;
    checks++;
    if (obs !== 31'd0) begin
      failures++; $display("FAIL mid_reset_async got=%h exp=%h", obs, 31'd0);
    end
    cur_level = '0;
    cur_sw    = '0;
    for (int k = 0; k < 3; k++) begin
      tick(); e = exp_now(); checks++;
      if (obs !== e) begin failures++; $display("FAIL mid_reset_hold cyc=%0d got=%h exp=%h", cyc, obs, e); end
    end
    RESET_N = 1'b1;
    cr = cyc;
    push_ev(cr + 6, 4'b1001, 4'b0, 4'b1001, 18'h3FFFF, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick(); e = exp_now(); checks++;
      if (obs !== e) begin failures++; $display("FAIL mid_reaccept cyc=%0d got=%h exp=%h", cyc, obs, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [30:0] e;
    int c0 = cyc;
    KEY_IN = 4'hF;
    push_ev(c0 + 6, 4'b0, 4'b1001, 4'b0000, 18'h3FFFF, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick(); e = exp_now(); checks++;
      if (obs !== e) begin failures++; $display("FAIL b2b_release cyc=%0d got=%h exp=%h", cyc, obs, e); end
    end
    c0 = cyc;
    KEY_IN = 4'h0;
    SW_IN  = 18'h1FFFF;
    push_ev(c0 + 6, 4'b1111, 4'b0, 4'b1111, 18'h1FFFF, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick(); e = exp_now(); checks++;
      if (obs !== e) begin failures++; $display("FAIL b2b_all_press cyc=%0d got=%h exp=%h", cyc, obs, e); end
    end
    c0 = cyc;
    KEY_IN = 4'hF;
    SW_IN  = 18'h3FFFF;
    push_ev(c0 + 6, 4'b0, 4'b1111, 4'b0000, 18'h3FFFF, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick(); e = exp_now(); checks++;
      if (obs !== e) begin failures++; $display("FAIL b2b_all_release cyc=%0d got=%h exp=%h", cyc, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_key_press();
    test_glitch();
    test_min_pulse();
    test_switch();
    test_repeat();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "timeout");
  end

endmodule
